disp_traces: RTL and testbench



---
 rtl/disp_traces_pkg.sv | 21 ++
 rtl/disp_traces_if.sv | 15 +
 rtl/disp_traces_trace_buffer.sv | 22 ++
 rtl/disp_traces.sv | 190 +++++++++++++++++++
 tb/tb_disp_traces.sv | 493 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/disp_traces_pkg.sv
// Shared types and the sample-to-row scaling helper for the multi-channel
// trace renderer.
package disp_pkg;

   typedef enum logic [1:0] {Idle, Arm, Capture, Draw} state_t;
   typedef enum logic [1:0] {PLoad, PCalc, PReq, PGap} phase_t;
   typedef logic [15:0] colour_t;

   // Row 0 is the top of the screen, so large samples land near row 0.
   function automatic int unsigned yscale(
      input int unsigned sample,
      input int unsigned h,
      input int unsigned sw
   );
      int unsigned p;
      p = (sample * h) >> sw;
      if (p > h - 1) p = h - 1;
      return h - 1 - p;
   endfunction

endpackage

// File: rtl/disp_traces_if.sv
// Pixel write port towards the display arbiter.
interface arbiter_if #(
   parameter int AW = 32
);
   import disp_pkg::*;

   logic req;
   logic ack;
   logic wr;
   logic [AW-1:0] addr;
   colour_t data;

   modport master(output req, addr, data, wr, input ack);
   modport slave(input req, addr, data, wr, output ack);
endinterface

// File: rtl/disp_traces_trace_buffer.sv
// Sample store: one write port for capture, one registered read port for draw.
module trace_buffer #(
   parameter int DEPTH = 320,
   parameter int DW = 20,
   parameter int AW = 9
) (
   input  logic clk,
   input  logic we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/disp_traces.sv
// Multi-channel trace renderer: capture W beats, then draw CH connected traces.
// Optional trigger-armed capture is enabled by DISP_TRACES_TRIGGER_EN.
module disp_traces
   import disp_pkg::*;
#(
   parameter int CH = 2,
   parameter int SW = 10,
   parameter int W = 320,
   parameter int H = 240,
   parameter int unsigned BASE = 0,
   parameter int unsigned SWAP = 0,
   parameter logic [63:0] COLOURS = 64'hffe0_001f_07e0_f800,
   parameter int AW = 32
) (
   input  logic clkSYS,
   input  logic reset,
   input  logic start,
   output logic done,
   input  logic stat,
   input  logic smpl_valid,
   output logic smpl_ready,
   input  logic [CH*SW-1:0] smpl_data,
   input  logic [SW-1:0] trig_level,
   arbiter_if.master arb
);

   localparam int XW = (W > 1) ? $clog2(W) : 1;
   localparam int YW = (H > 1) ? $clog2(H) : 1;
   localparam int CW = (CH > 1) ? $clog2(CH) : 1;
   localparam logic [XW-1:0] XLAST = XW'(W - 1);
   localparam logic [CW-1:0] CLAST = CW'(CH - 1);

   state_t state;
   phase_t phase;
   logic [XW-1:0] x;
   logic [CW-1:0] ch;
   logic [YW-1:0] yprev, ydest, ycur;
   logic [YW-1:0] yd, yfirst, ystep;
   logic [AW-1:0] base;
   logic [CH*SW-1:0] rd_data;
   logic [SW-1:0] smp;
   colour_t colour;
   logic beat, store;

   function automatic logic [AW-1:0] pix_addr(
      input logic [AW-1:0] b,
      input logic [YW-1:0] y,
      input logic [XW-1:0] c
   );
      return b | (AW'(y) * AW'(W) + AW'(c));
   endfunction

   trace_buffer #(.DEPTH(W), .DW(CH*SW), .AW(XW)) u_buf (
      .clk(clkSYS),
      .we(store),
      .waddr(x),
      .wdata(smpl_data),
      .raddr(x),
      .rdata(rd_data)
   );

   assign arb.wr = 1'b1;
   assign beat = smpl_valid && smpl_ready;
   assign smp = rd_data[32'(ch)*SW +: SW];
   assign colour = COLOURS[{ch, 4'b0} +: 16];
   assign yd = YW'(yscale(32'(smp), H, SW));
   assign ystep = (ycur < ydest) ? ycur + 1'b1 : ycur - 1'b1;

   // First pixel of a column steps one row off the previous column's end.
   always_comb begin
      yfirst = yd;
      if (x != '0 && yprev != yd)
         yfirst = (yprev < yd) ? yprev + 1'b1 : yprev - 1'b1;
   end

`ifdef DISP_TRACES_TRIGGER_EN
   localparam int TW = $clog2(4 * W) + 1;
   logic [SW-1:0] prev;
   logic prev_ok;
   logic [TW-1:0] cnt;
   logic trig, timeout;

   assign trig = prev_ok && prev < trig_level
              && smpl_data[SW-1:0] >= trig_level;
   assign timeout = beat && !trig && cnt == TW'(4 * W - 1);
   assign store = beat && (state == Capture || (state == Arm && trig));

   always_ff @(posedge clkSYS) begin
      if (reset || state == Idle) begin
         prev <= '0;
         prev_ok <= 1'b0;
         cnt <= '0;
      end else if (state == Arm && beat) begin
         prev <= smpl_data[SW-1:0];
         prev_ok <= 1'b1;
         if (!trig) cnt <= cnt + 1'b1;
      end
   end
`else
   logic unused_trig;
   assign unused_trig = ^trig_level;
   assign store = beat;
`endif

   always_ff @(posedge clkSYS) begin
      if (reset) begin
         state <= Idle;
         phase <= PLoad;
         x <= '0;
         ch <= '0;
         yprev <= '0;
         ydest <= '0;
         ycur <= '0;
         base <= '0;
         done <= 1'b0;
         smpl_ready <= 1'b0;
         arb.req <= 1'b0;
         arb.addr <= '0;
         arb.data <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            Idle: if (start) begin
               state <= Arm;
               smpl_ready <= 1'b1;
               base <= stat ? AW'(SWAP) : AW'(BASE);
               x <= '0;
               ch <= '0;
            end
            Arm: begin
`ifdef DISP_TRACES_TRIGGER_EN
               if (timeout) state <= Capture;
`else
               state <= Capture;
`endif
            end
            Capture: ;
            Draw: unique case (phase)
               PLoad: phase <= PCalc;
               PCalc: begin
                  ydest <= yd;
                  ycur <= yfirst;
                  arb.addr <= pix_addr(base, yfirst, x);
                  arb.data <= colour;
                  arb.req <= 1'b1;
                  phase <= PReq;
               end
               PReq: if (arb.ack) begin
                  arb.req <= 1'b0;
                  if (ycur == ydest) begin
                     yprev <= ydest;
                     phase <= PLoad;
                     if (x == XLAST) begin
                        x <= '0;
                        if (ch == CLAST) begin
                           state <= Idle;
                           done <= 1'b1;
                        end else begin
                           ch <= ch + 1'b1;
                        end
                     end else begin
                        x <= x + 1'b1;
                     end
                  end else begin
                     ycur <= ystep;
                     arb.addr <= pix_addr(base, ystep, x);
                     phase <= PGap;
                  end
               end
               PGap: begin
                  arb.req <= 1'b1;
                  phase <= PReq;
               end
            endcase
         endcase
         if (store) begin
            if (x == XLAST) begin
               x <= '0;
               smpl_ready <= 1'b0;
               state <= Draw;
               phase <= PLoad;
            end else begin
               x <= x + 1'b1;
               state <= Capture;
            end
         end
      end
   end

endmodule

// File: tb/tb_disp_traces.sv
// Randomised self-checking bench for disp_traces against a pixel-list model.
module tb_disp_traces;
   import disp_pkg::*;

   localparam int CH = 2;
   localparam int SW = 4;
   localparam int W = 8;
   localparam int H = 16;
   localparam int AW = 16;
   localparam int unsigned SWAPV = 32'h100;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic start = 1'b0;
   logic done;
   logic stat = 1'b0;
   logic smpl_valid = 1'b0;
   logic smpl_ready;
   logic [CH*SW-1:0] smpl_data = '0;
   logic [SW-1:0] trig_level = 4'd8;

   arbiter_if #(.AW(AW)) arb();

   disp_traces #(
      .CH(CH), .SW(SW), .W(W), .H(H),
      .BASE(0), .SWAP(SWAPV),
      .COLOURS(64'hffe0_001f_07e0_f800), .AW(AW)
   ) dut (
      .clkSYS(clk),
      .reset(reset),
      .start(start),
      .done(done),
      .stat(stat),
      .smpl_valid(smpl_valid),
      .smpl_ready(smpl_ready),
      .smpl_data(smpl_data),
      .trig_level(trig_level),
      .arb(arb)
   );

   colour_t col [4] = '{16'hf800, 16'h07e0, 16'h001f, 16'hffe0};
   int tests = 0;
   int fails = 0;
   logic [31:0] got[$];
   logic [31:0] exp_q[$];
   int holds[$];
   int unstable = 0;
   int done_cnt = 0;
   int ack_delay = 1;
   int acc = 0;
   int nbeats = 0;
   int leak = 0;
   bit spur = 1'b0;
   bit tmo = 1'b0;

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   // Arbiter stand-in: acks after ack_delay observed req cycles.
   initial begin
      int cnt;
      logic [31:0] snap;
      arb.ack = 1'b0;
      cnt = 0;
      snap = '0;
      forever begin
         @(posedge clk);
         #1;
         if (arb.ack) begin
            arb.ack = 1'b0;
            cnt = 0;
         end else if (arb.req) begin
            if (cnt == 0) snap = {arb.addr, arb.data};
            else if ({arb.addr, arb.data} !== snap) unstable++;
            cnt++;
            if (cnt >= ack_delay) begin
               arb.ack = 1'b1;
               got.push_back(snap);
               holds.push_back(cnt);
            end
         end else begin
            cnt = 0;
            if (spur && $urandom_range(0, 2) == 0) arb.ack = 1'b1;
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (done === 1'b1) done_cnt++;
      end
   end

   function automatic int model(input logic [7:0] s[$], input bit st);
      int c0, yp, yd, sv, stp, y;
      logic [AW-1:0] b;
      logic [7:0] v;
      c0 = 0;
`ifdef DISP_TRACES_TRIGGER_EN
      begin
         logic [3:0] prev, cur;
         bit pok;
         int cnt;
         pok = 1'b0;
         cnt = 0;
         c0 = -1;
         prev = '0;
         for (int i = 0; i < s.size() && c0 < 0; i++) begin
            v = s[i];
            cur = v[3:0];
            if (pok && prev < trig_level && cur >= trig_level) c0 = i;
            else begin
               cnt++;
               if (cnt == 4 * W) c0 = i + 1;
            end
            prev = cur;
            pok = 1'b1;
         end
         if (c0 < 0) c0 = 0;
      end
`endif
      b = st ? AW'(SWAPV) : '0;
      exp_q.delete();
      yp = 0;
      for (int c = 0; c < CH; c++) begin
         for (int x = 0; x < W; x++) begin
            v = s[c0 + x];
            sv = int'(v[c*SW +: SW]);
            yd = (H - 1) - ((sv * H) >> SW);
            if (x == 0 || yd == yp) begin
               exp_q.push_back({b | AW'(yd * W + x), col[c]});
            end else begin
               stp = (yd > yp) ? 1 : -1;
               y = yp;
               do begin
                  y += stp;
                  exp_q.push_back({b | AW'(y * W + x), col[c]});
               end while (y != yd);
            end
            yp = yd;
         end
      end
      return c0 + W;
   endfunction

   task automatic kick(input logic [7:0] s[$], input bit st);
      int g;
      nbeats = model(s, st);
      got.delete();
      holds.delete();
      unstable = 0;
      done_cnt = 0;
      leak = 0;
      acc = 0;
      tmo = 1'b0;
      stat = st;
      tick;
      start = 1'b1;
      tick;
      start = 1'b0;
      g = 0;
      while (acc < nbeats && g < 1000) begin
         bit rdy;
         smpl_valid = ($urandom_range(0, 3) != 0);
         smpl_data = s[acc];
         rdy = smpl_ready;
         tick;
         g++;
         if (smpl_valid && rdy) acc++;
      end
      smpl_valid = 1'b0;
   endtask

   task automatic finish_render(input bit st, input bit toggle);
      int g;
      g = 0;
      while (done_cnt == 0 && g < 4000) begin
         smpl_valid = 1'b1;
         smpl_data = (CH*SW)'($urandom);
         if (smpl_ready) leak++;
         start = toggle && got.size() == 3;
         if (toggle && got.size() >= 3) stat = ~st;
         tick;
         g++;
      end
      tmo = (done_cnt == 0);
      smpl_valid = 1'b0;
      start = 1'b0;
      repeat (4) tick;
   endtask

   task automatic do_render(input logic [7:0] s[$], input bit st,
                            input bit toggle);
      kick(s, st);
      finish_render(st, toggle);
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) tick;
      tests++;
      if (done !== 1'b0) begin
         fails++;
         $display("FAIL reset_done: got %b want 0", done);
      end
      tests++;
      if (smpl_ready !== 1'b0) begin
         fails++;
         $display("FAIL reset_ready: got %b want 0", smpl_ready);
      end
      tests++;
      if (arb.req !== 1'b0) begin
         fails++;
         $display("FAIL reset_req: got %b want 0", arb.req);
      end
      tests++;
      if (arb.wr !== 1'b1) begin
         fails++;
         $display("FAIL wr_tied: got %b want 1", arb.wr);
      end
      reset = 1'b0;
      tick;
   endtask

   task automatic test_flat;
      logic [7:0] s[$];
      for (int i = 0; i < W; i++) s.push_back({4'hf, 4'h0});
      do_render(s, 1'b0, 1'b0);
      tests++;
      if (tmo || done_cnt != 1) begin
         fails++;
         $display("FAIL flat_done: got %0d pulses want 1", done_cnt);
      end
      tests++;
      if (got.size() != 16) begin
         fails++;
         $display("FAIL flat_count: got %0d want 16", got.size());
      end
      tests++;
      if (got.size() < 9 || got[0] !== {16'd120, 16'hf800}
          || got[8] !== {16'd0, 16'h07e0}) begin
         fails++;
         $display("FAIL flat_first: got %h/%h want 0078f800/000007e0",
                  got.size() > 0 ? got[0] : 32'h0,
                  got.size() > 8 ? got[8] : 32'h0);
      end
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
         tests++;
         if (got[i] !== exp_q[i]) begin
            fails++;
            $display("FAIL flat_px%0d: got %h want %h", i, got[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_step;
      logic [7:0] s[$];
      logic [3:0] c0v [8] = '{0, 0, 0, 8, 8, 0, 0, 0};
      int n0;
      for (int i = 0; i < W; i++) s.push_back({4'($urandom), c0v[i]});
      do_render(s, 1'b0, 1'b0);
      n0 = 0;
      foreach (got[i]) if (got[i][15:0] == 16'hf800) n0++;
      tests++;
      if (n0 != 22) begin
         fails++;
         $display("FAIL step_ch0_count: got %0d want 22", n0);
      end
      tests++;
      if (tmo || done_cnt != 1 || got.size() != exp_q.size()) begin
         fails++;
         $display("FAIL step_done: pulses %0d px %0d want 1 px %0d",
                  done_cnt, got.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
         tests++;
         if (got[i] !== exp_q[i]) begin
            fails++;
            $display("FAIL step_px%0d: got %h want %h", i, got[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_stall;
      logic [7:0] s[$];
      int bad;
      for (int i = 0; i < W; i++) s.push_back(8'($urandom));
      ack_delay = 5;
      do_render(s, 1'b0, 1'b0);
      ack_delay = 1;
      bad = 0;
      foreach (holds[i]) if (holds[i] != 5) bad++;
      tests++;
      if (bad != 0 || holds.size() == 0) begin
         fails++;
         $display("FAIL stall_hold: got %0d bad holds want 0", bad);
      end
      tests++;
      if (unstable != 0) begin
         fails++;
         $display("FAIL stall_stable: got %0d changes want 0", unstable);
      end
      tests++;
      if (tmo || done_cnt != 1 || got.size() != exp_q.size()) begin
         fails++;
         $display("FAIL stall_done: pulses %0d px %0d want 1 px %0d",
                  done_cnt, got.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
         tests++;
         if (got[i] !== exp_q[i]) begin
            fails++;
            $display("FAIL stall_px%0d: got %h want %h", i, got[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_stat;
      logic [7:0] s[$];
      int bad;
      for (int i = 0; i < W; i++) s.push_back(8'($urandom));
      do_render(s, 1'b1, 1'b1);
      stat = 1'b0;
      bad = 0;
      foreach (got[i]) if (got[i][24] !== 1'b1) bad++;
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL stat_base: got %0d addrs without 100 want 0", bad);
      end
      tests++;
      if (tmo || done_cnt != 1 || leak != 0) begin
         fails++;
         $display("FAIL stat_done: pulses %0d ready_leak %0d want 1 0",
                  done_cnt, leak);
      end
      tests++;
      if (got.size() != exp_q.size()) begin
         fails++;
         $display("FAIL stat_count: got %0d want %0d", got.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
         tests++;
         if (got[i] !== exp_q[i]) begin
            fails++;
            $display("FAIL stat_px%0d: got %h want %h", i, got[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_reset_mid_draw;
      logic [7:0] s[$];
      logic [7:0] s2[$];
      int g;
      for (int i = 0; i < W; i++) s.push_back({4'hf, 4'h0});
      kick(s, 1'b0);
      g = 0;
      while (got.size() < 5 && g < 500) begin
         tick;
         g++;
      end
      tests++;
      if (got.size() < 5) begin
         fails++;
         $display("FAIL mid_wait: got %0d acks want 5", got.size());
      end
      reset = 1'b1;
      tick;
      tests++;
      if (arb.req !== 1'b0) begin
         fails++;
         $display("FAIL mid_req: got %b want 0", arb.req);
      end
      reset = 1'b0;
      repeat (8) tick;
      tests++;
      if (done_cnt != 0) begin
         fails++;
         $display("FAIL mid_done: got %0d pulses want 0", done_cnt);
      end
      for (int i = 0; i < W; i++) s2.push_back(8'($urandom));
      do_render(s2, 1'b0, 1'b0);
      tests++;
      if (tmo || done_cnt != 1 || got.size() != exp_q.size()) begin
         fails++;
         $display("FAIL mid_rerun: pulses %0d px %0d want 1 px %0d",
                  done_cnt, got.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
         tests++;
         if (got[i] !== exp_q[i]) begin
            fails++;
            $display("FAIL mid_px%0d: got %h want %h", i, got[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_random;
      for (int r = 0; r < 4; r++) begin
         logic [7:0] s[$];
         bit st;
         for (int i = 0; i < W; i++) s.push_back(8'($urandom));
         st = 1'($urandom);
         spur = 1'b1;
         ack_delay = $urandom_range(1, 3);
         do_render(s, st, 1'b0);
         spur = 1'b0;
         ack_delay = 1;
         tests++;
         if (tmo || done_cnt != 1 || got.size() != exp_q.size()) begin
            fails++;
            $display("FAIL rand%0d_done: pulses %0d px %0d want 1 px %0d",
                     r, done_cnt, got.size(), exp_q.size());
         end
         for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            tests++;
            if (got[i] !== exp_q[i]) begin
               fails++;
               $display("FAIL rand%0d_px%0d: got %h want %h",
                        r, i, got[i], exp_q[i]);
            end
         end
      end
   endtask

`ifdef DISP_TRACES_TRIGGER_EN
   task automatic test_trigger;
      logic [7:0] s[$];
      logic [7:0] s2[$];
      logic [3:0] pre [4] = '{2, 4, 6, 9};
      for (int i = 0; i < 4; i++) s.push_back({4'($urandom), pre[i]});
      for (int i = 0; i < W - 1; i++) s.push_back(8'($urandom));
      do_render(s, 1'b0, 1'b0);
      tests++;
      if (got.size() == 0 || got[0] !== {16'd48, 16'hf800}) begin
         fails++;
         $display("FAIL trig_first: got %h want 0030f800",
                  got.size() > 0 ? got[0] : 32'h0);
      end
      tests++;
      if (tmo || done_cnt != 1 || acc != nbeats) begin
         fails++;
         $display("FAIL trig_done: pulses %0d beats %0d want 1 %0d",
                  done_cnt, acc, nbeats);
      end
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
         tests++;
         if (got[i] !== exp_q[i]) begin
            fails++;
            $display("FAIL trig_px%0d: got %h want %h", i, got[i], exp_q[i]);
         end
      end
      for (int i = 0; i < 4 * W + W; i++) s2.push_back({4'($urandom), 4'd3});
      do_render(s2, 1'b0, 1'b0);
      tests++;
      if (tmo || done_cnt != 1 || acc != 4 * W + W) begin
         fails++;
         $display("FAIL trig_timeout: pulses %0d beats %0d want 1 %0d",
                  done_cnt, acc, 4 * W + W);
      end
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
         tests++;
         if (got[i] !== exp_q[i]) begin
            fails++;
            $display("FAIL tmo_px%0d: got %h want %h", i, got[i], exp_q[i]);
         end
      end
   endtask
`endif

   initial begin
      test_reset;
`ifdef DISP_TRACES_TRIGGER_EN
      test_trigger;
`else
      test_flat;
      test_step;
      test_stall;
      test_stat;
      test_reset_mid_draw;
      test_random;
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
